sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Parametrised N-client SDRAM access arbiter with a priority ROM/ioctl download port; replaces ad-hoc download/CPU muxing.
//  Sits between guest_top clients (CPU, video fetch, DMA) and the single-port sdram controller.
//  Grants one access at a time; req/ack handshake per client, round-robin fairness, download port absolute priority.
// PARAMETERS
//  NUM_CLIENTS    3   number of client ports (1..8)
//  ADDR_W        23   address width, all ports
//  DATA_W         8   data width, all ports
//  DL_FIFO_DEPTH  4   download write FIFO depth, power of 2 >=2 (used only with SDRAM_ARB_DL_FIFO_EN)
// PORTS
//  clk_sys     in   1                    single clock for the whole block
//  reset_n     in   1                    asynchronous, active-low reset
//  cli_req     in   NUM_CLIENTS          level request per client, held until its cli_ack
//  cli_we      in   NUM_CLIENTS          1=write, 0=read; stable while cli_req
//  cli_addr    in   NUM_CLIENTS*ADDR_W   packed, client i at [i*ADDR_W +: ADDR_W]
//  cli_wdata   in   NUM_CLIENTS*DATA_W   packed write data
//  cli_ack     out  NUM_CLIENTS          one-cycle completion pulse (one-hot or zero)
//  cli_rdata   out  DATA_W               read data, valid in cycle cli_ack pulses; held otherwise
//  dl_active   in   1                    download in progress (ioctl_download)
//  dl_wr       in   1                    download write strobe, one cycle per byte
//  dl_addr     in   ADDR_W               download address
//  dl_data     in   DATA_W               download data
//  dl_busy     out  1                    download storage full; source must hold off dl_wr
//  dl_overflow out  1                    sticky: dl_wr arrived while dl_busy
//  mem_req     out  1                    request to sdram, held until mem_ack
//  mem_we      out  1                    write enable qualifying mem_req
//  mem_addr    out  ADDR_W               access address
//  mem_din     out  DATA_W               write data to sdram
//  mem_dout    in   DATA_W               read data from sdram, valid with mem_ack
//  mem_ack     in   1                    one-cycle access-complete pulse
// BEHAVIOUR
//  Reset (reset_n=0, any time, incl. mid-access): state IDLE, all outputs 0, rr pointer=0, download storage emptied, dl_overflow=0.
//  FSM IDLE: if download entry pending -> grant DL; else if !dl_active and any cli_req -> grant first requester at/after rr pointer -> ISSUE.
//  While dl_active=1 clients are never granted (pending cli_req wait); an access already in flight completes normally.
//  ISSUE: mem_req/we/addr/din registered from granted source; held constant until mem_ack -> DONE.
//  DONE (1 cycle): client grant -> cli_ack[g]=1, cli_rdata<=mem_dout (reads; writes leave cli_rdata); rr pointer <= g+1 mod NUM_CLIENTS. DL grant pops entry. -> IDLE.
//  Latency: req sampled in IDLE at cycle 0 -> mem_req at 1; mem_ack at cycle k -> cli_ack at k+1; next grant earliest k+2.
//  mem_ack outside ISSUE ignored. Client dropping cli_req before ack: protocol violation, access still completes and acks.
//  dl_wr with dl_busy=0: entry stored same cycle. dl_wr with dl_busy=1: dropped, dl_overflow<=1.
//  dl_overflow cleared on rising edge of dl_active. dl_wr with dl_active=0 ignored.
//  Simultaneous dl_wr and DONE pop: both take effect; occupancy unchanged.
// CONFIGURATION
//  SDRAM_ARB_DL_FIFO_EN defined: download storage is a DL_FIFO_DEPTH FIFO; dl_busy=full; bursts up to DEPTH absorbed.
//  Undefined: single holding register; dl_busy=1 from store until its DONE; DL_FIFO_DEPTH unused.
// STRUCTURE
//  Package sdram_arb_pkg: arb_state_e {IDLE,ISSUE,DONE}; typedef grant source (client index + DL flag); function rr_pick(req,ptr).
//  Sub-module sdram_arb_dl_fifo (sync FIFO, push/pop/full/empty), instantiated only under SDRAM_ARB_DL_FIFO_EN.
// TESTING
//  Single client 0 read addr 0x000123, mem_dout=0xA5, mem_ack at cycle 4 -> mem_req cycles 1..4, cli_ack[0] cycle 5, cli_rdata=0xA5.
//  Clients 0,1,2 req continuously -> grants 0,1,2,0,1,2; no client starved; cli_ack one-hot.
//  dl_active=1, client 1 req, 3 dl_wr to 0x000000..0x000002 -> three mem writes in order, then client 1 served only after dl_active=0.
//  FIFO off: two back-to-back dl_wr -> second dropped, dl_overflow=1; new dl_active rise -> 0. FIFO on (DEPTH=4): 4 back-to-back accepted, 5th sets overflow.
//  reset_n low during ISSUE -> mem_req=0 immediately, no cli_ack after release, rr pointer=0.
//  Stray mem_ack in IDLE -> no cli_ack, no state change.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state, grant-source type and round-robin pick helper for sdram_port_arbiter
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} arb_state_e;
  typedef struct packed {
    logic       dl;
    logic [2:0] idx;
  } grant_t;
  // returns {found, index} of the first set request at or after ptr, wrapping at n clients
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [3:0] r;
    logic [3:0] j;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      j = {1'b0, ptr} + 4'(k);
      j = (j >= 4'(n)) ? j - 4'(n) : j;
      if (k < n && req[j[2:0]]) r = {1'b1, j[2:0]};
    end
    return r;
  endfunction
endpackage

// File: rtl/sdram_arb_dl_fifo.sv
// sdram_arb_dl_fifo: synchronous FIFO buffering download writes ahead of the arbiter
module sdram_arb_dl_fifo #(
  parameter int W     = 31,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = wr_q == rd_q;
  assign dout  = mem_q[rd_q[AW-1:0]];
  // pointers advance on accepted push/pop; the extra MSB tells full from empty
  always_comb begin
    wr_d = (push && !full) ? wr_q + ONE : wr_q;
    rd_d = (pop && !empty) ? rd_q + ONE : rd_q;
  end
  // pointer registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  // storage array, no reset needed since empty masks stale entries
  always_ff @(posedge clk)
    if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: N-client round-robin SDRAM arbiter with an absolute-priority download port.
// Define SDRAM_ARB_DL_FIFO_EN to buffer download writes in a DL_FIFO_DEPTH FIFO instead of one holding register.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS   = 3,
  parameter int ADDR_W        = 23,
  parameter int DATA_W        = 8,
  parameter int DL_FIFO_DEPTH = 4
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic [NUM_CLIENTS-1:0]        cli_req,
  input  logic [NUM_CLIENTS-1:0]        cli_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata,
  output logic [NUM_CLIENTS-1:0]        cli_ack,
  output logic [DATA_W-1:0]             cli_rdata,
  input  logic                          dl_active,
  input  logic                          dl_wr,
  input  logic [ADDR_W-1:0]             dl_addr,
  input  logic [DATA_W-1:0]             dl_data,
  output logic                          dl_busy,
  output logic                          dl_overflow,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_din,
  input  logic [DATA_W-1:0]             mem_dout,
  input  logic                          mem_ack
);
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [2:0] LAST = 3'(NUM_CLIENTS - 1);
  arb_state_e state_q, state_d;
  grant_t grant_q, grant_d;
  logic [2:0] ptr_q, ptr_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, act_q, ovf_q, ovf_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d, rdata_q, rdata_d;
  logic st_valid, push, pop;
  logic [EW-1:0] st_head;
  logic [3:0] pick;
  logic [NUM_CLIENTS-1:0] ack_vec;
  assign push = dl_wr && dl_active && !dl_busy;
  assign pop  = (state_q == DONE) && grant_q.dl;
`ifdef SDRAM_ARB_DL_FIFO_EN
  logic st_empty;
  sdram_arb_dl_fifo #(.W(EW), .DEPTH(DL_FIFO_DEPTH)) u_dl_fifo (
    .clk(clk_sys), .rst_n(reset_n), .push(push), .pop(pop), .din({dl_addr, dl_data}),
    .dout(st_head), .full(dl_busy), .empty(st_empty)
  );
  assign st_valid = !st_empty;
`else
  logic hold_valid_q, hold_valid_d;
  logic [EW-1:0] hold_q, hold_d;
  // single holding register, occupied from store until its access completes
  always_comb begin
    hold_valid_d = push ? 1'b1 : (pop ? 1'b0 : hold_valid_q);
    hold_d = push ? {dl_addr, dl_data} : hold_q;
  end
  // holding register state
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      hold_valid_q <= 1'b0;
      hold_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q <= hold_d;
    end
  assign st_valid = hold_valid_q;
  assign st_head  = hold_q;
  assign dl_busy  = hold_valid_q;
`endif
  // arbitration FSM: download first, clients round-robin only while no download is active
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d = mem_din_q;
    rdata_d = rdata_q;
    pick = rr_pick(8'(cli_req), ptr_q, NUM_CLIENTS);
    case (state_q)
      IDLE:
        if (st_valid) begin
          state_d = ISSUE;
          grant_d = '{dl: 1'b1, idx: 3'd0};
          mem_req_d = 1'b1;
          mem_we_d = 1'b1;
          mem_addr_d = st_head[DATA_W +: ADDR_W];
          mem_din_d = st_head[DATA_W-1:0];
        end else if (!dl_active && pick[3]) begin
          state_d = ISSUE;
          grant_d = '{dl: 1'b0, idx: pick[2:0]};
          mem_req_d = 1'b1;
          mem_we_d = cli_we[pick[2:0]];
          mem_addr_d = cli_addr[pick[2:0]*ADDR_W +: ADDR_W];
          mem_din_d = cli_wdata[pick[2:0]*DATA_W +: DATA_W];
        end
      ISSUE:
        if (mem_ack) begin
          state_d = DONE;
          mem_req_d = 1'b0;
          rdata_d = (!grant_q.dl && !mem_we_q) ? mem_dout : rdata_q;
        end
      DONE: begin
        state_d = IDLE;
        ptr_d = grant_q.dl ? ptr_q : (grant_q.idx == LAST ? 3'd0 : grant_q.idx + 3'd1);
      end
      default: state_d = IDLE;
    endcase
  end
  // sticky overflow, cleared when a new download starts
  always_comb ovf_d = (ovf_q && !(dl_active && !act_q)) || (dl_wr && dl_active && dl_busy);
  // one-hot acknowledge vector for the granted client
  always_comb
    for (int i = 0; i < NUM_CLIENTS; i++) ack_vec[i] = grant_q.idx == 3'(i);
  // state registers
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      rdata_q <= '0;
      act_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      rdata_q <= rdata_d;
      act_q <= dl_active;
      ovf_q <= ovf_d;
    end
  assign cli_ack = (state_q == DONE && !grant_q.dl) ? ack_vec : '0;
  assign cli_rdata = rdata_q;
  assign dl_overflow = ovf_q;
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din = mem_din_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: self-checking bench with an SDRAM responder model and client scoreboard
module tb_sdram_port_arbiter;
  localparam int N = 3, AW = 23, DW = 8;
  localparam int CAP =
`ifdef SDRAM_ARB_DL_FIFO_EN
    4;
`else
    1;
`endif
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;
  logic clk_sys = 1'b0, reset_n = 1'b0;
  logic [N-1:0] cli_req, cli_we, cli_ack;
  logic [N*AW-1:0] cli_addr;
  logic [N*DW-1:0] cli_wdata;
  logic [DW-1:0] cli_rdata, dl_data, mem_din, mem_dout;
  logic dl_active, dl_wr, dl_busy, dl_overflow, mem_req, mem_we, mem_ack;
  logic [AW-1:0] dl_addr, mem_addr;
  int checks = 0, fails = 0, model_ptr = 0, resp_delay = 0;
  bit resp_en = 1'b1, resp_fixed = 1'b0, stray_go = 1'b0;
  acc_t acc_q[$];
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  logic t_we [N];
  logic [AW-1:0] t_addr [N];
  logic [DW-1:0] t_data [N];
  int served [N];

  sdram_port_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .DL_FIFO_DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr),
    .cli_wdata(cli_wdata), .cli_ack(cli_ack), .cli_rdata(cli_rdata), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_busy(dl_busy), .dl_overflow(dl_overflow), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: acks after a delay, logs every completed access, garbage on mem_dout otherwise
  initial begin : responder
    int wait_cnt, lim;
    acc_t a;
    mem_ack = 1'b0;
    mem_dout = '0;
    wait_cnt = 0;
    lim = 0;
    forever begin
      @(negedge clk_sys);
      if (mem_ack) begin
        mem_ack = 1'b0;
        mem_dout = 8'($urandom);
      end else if (stray_go) begin
        mem_ack = 1'b1;
        stray_go = 1'b0;
      end else if (!mem_req) wait_cnt = 0;
      else if (resp_en) begin
        if (wait_cnt == 0) lim = resp_fixed ? resp_delay : int'($urandom_range(0, 4));
        if (wait_cnt >= lim) begin
          a.we = mem_we;
          a.addr = mem_addr;
          if (mem_we) begin
            a.data = mem_din;
            mem_model[mem_addr] = mem_din;
          end else begin
            a.data = mem_model.exists(mem_addr) ? mem_model[mem_addr] : (mem_addr[DW-1:0] ^ 8'h5a);
            mem_dout = a.data;
          end
          acc_q.push_back(a);
          mem_ack = 1'b1;
          wait_cnt = 0;
        end else wait_cnt++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_txn(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    t_we[i] = we;
    t_addr[i] = addr;
    t_data[i] = data;
    cli_we[i] = we;
    cli_addr[i*AW +: AW] = addr;
    cli_wdata[i*DW +: DW] = data;
    cli_req[i] = 1'b1;
  endtask

  task automatic new_txn(input int i);
    set_txn(i, 1'($urandom_range(0, 1)), 23'($urandom_range(0, 63)), 8'($urandom));
  endtask

  // client traffic: n accesses over the clients in mask; continuous or random re-requests
  task automatic serve(input int n, input logic [N-1:0] mask, input bit rnd, input bit rr_chk);
    int got, issued, cyc, g, ex;
    acc_t a;
    got = 0;
    issued = 0;
    cyc = 0;
    for (int i = 0; i < N; i++)
      if (mask[i] && issued < n) begin
        new_txn(i);
        issued++;
      end
    while ((got < n || cli_req != '0) && cyc < 4000) begin
      @(negedge clk_sys);
      cyc++;
      if (cli_ack != '0) begin
        checks++;
        if (!$onehot(cli_ack)) begin fails++; $display("FAIL ack_onehot: got %b required one-hot", cli_ack); end
        g = 0;
        for (int i = N - 1; i >= 0; i--) if (cli_ack[i]) g = i;
        checks++;
        if (!cli_req[g]) begin fails++; $display("FAIL ack_unrequested: ack %b req %b", cli_ack, cli_req); end
        checks++;
        if (acc_q.size() == 0) begin fails++; $display("FAIL bus_access: client %0d acked with no memory access", g); end
        else begin
          a = acc_q.pop_front();
          if (a.we !== t_we[g] || a.addr !== t_addr[g] || (t_we[g] && a.data !== t_data[g])) begin
            fails++;
            $display("FAIL bus_txn: client %0d bus we=%b addr=%h data=%h required we=%b addr=%h data=%h", g, a.we, a.addr, a.data, t_we[g], t_addr[g], t_data[g]);
          end
          if (!t_we[g]) begin
            checks++;
            if (cli_rdata !== a.data) begin fails++; $display("FAIL rdata: client %0d got %h required %h", g, cli_rdata, a.data); end
          end
        end
        if (rr_chk) begin
          ex = -1;
          for (int k = N - 1; k >= 0; k--) if (mask[(model_ptr + k) % N]) ex = (model_ptr + k) % N;
          checks++;
          if (g != ex) begin fails++; $display("FAIL rr_order: granted %0d required %0d", g, ex); end
        end
        model_ptr = (g + 1) % N;
        served[g]++;
        got++;
        if (issued < n && (!rnd || $urandom_range(0, 1) == 1)) begin
          new_txn(g);
          issued++;
        end else cli_req[g] = 1'b0;
      end
      if (rnd)
        for (int i = 0; i < N; i++)
          if (mask[i] && !cli_req[i] && issued < n && $urandom_range(0, 2) == 0) begin
            new_txn(i);
            issued++;
          end
    end
    checks++;
    if (got < n || cli_req != '0) begin fails++; $display("FAIL serve_timeout: %0d of %0d acks, req %b", got, n, cli_req); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({cli_ack, cli_rdata, dl_busy, dl_overflow, mem_req, mem_we, mem_addr, mem_din} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b rdata=%h busy=%b ovf=%b req=%b we=%b addr=%h din=%h required all 0", cli_ack, cli_rdata, dl_busy, dl_overflow, mem_req, mem_we, mem_addr, mem_din);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ({cli_ack, mem_req} !== '0) begin fails++; $display("FAIL post_reset_idle: ack=%b req=%b required 0", cli_ack, mem_req); end
  endtask

  task automatic test_single_read();
    resp_fixed = 1'b1;
    resp_delay = 3;
    mem_model[23'h000123] = 8'ha5;
    @(negedge clk_sys);
    set_txn(0, 1'b0, 23'h000123, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_sys);
      checks++;
      if (c <= 4) begin
        if ({mem_req, mem_we, mem_addr, cli_ack} !== {1'b1, 1'b0, 23'h000123, 3'b000}) begin
          fails++;
          $display("FAIL single_read_issue: cycle %0d req=%b we=%b addr=%h ack=%b required 1 0 000123 000", c, mem_req, mem_we, mem_addr, cli_ack);
        end
      end else if ({mem_req, cli_ack, cli_rdata} !== {1'b0, 3'b001, 8'ha5}) begin
        fails++;
        $display("FAIL single_read_done: req=%b ack=%b rdata=%h required 0 001 a5", mem_req, cli_ack, cli_rdata);
      end
    end
    cli_req[0] = 1'b0;
    acc_q.delete();
    model_ptr = 1;
    resp_fixed = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < N; i++) served[i] = 0;
    serve(6, 3'b111, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (served[i] != 2) begin fails++; $display("FAIL rr_fairness: client %0d served %0d required 2", i, served[i]); end
    end
  endtask

  task automatic test_download();
    int cyc;
    acc_t a;
    @(negedge clk_sys);
    dl_active = 1'b1;
    set_txn(1, 1'b1, 23'h000040, 8'h77);
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      while (dl_busy && cyc < 200) begin
        @(negedge clk_sys);
        cyc++;
        checks++;
        if (cli_ack !== '0) begin fails++; $display("FAIL dl_client_blocked: ack %b during download", cli_ack); end
      end
      dl_wr = 1'b1;
      dl_addr = 23'(k);
      dl_data = 8'hc0 + 8'(k);
      @(negedge clk_sys);
      dl_wr = 1'b0;
    end
    cyc = 0;
    while (acc_q.size() < 3 && cyc < 200) begin
      @(negedge clk_sys);
      cyc++;
    end
    repeat (10) begin
      @(negedge clk_sys);
      checks++;
      if ({cli_ack, mem_req} !== '0) begin fails++; $display("FAIL dl_client_wait: ack=%b req=%b required 0 while dl_active", cli_ack, mem_req); end
    end
    checks++;
    if (acc_q.size() != 3) begin fails++; $display("FAIL dl_count: %0d accesses required 3", acc_q.size()); end
    for (int k = 0; k < 3 && acc_q.size() > 0; k++) begin
      a = acc_q.pop_front();
      checks++;
      if (a.we !== 1'b1 || a.addr !== 23'(k) || a.data !== 8'hc0 + 8'(k)) begin
        fails++;
        $display("FAIL dl_write: #%0d we=%b addr=%h data=%h required 1 %h %h", k, a.we, a.addr, a.data, 23'(k), 8'hc0 + 8'(k));
      end
    end
    dl_active = 1'b0;
    cyc = 0;
    while (cli_ack == '0 && cyc < 200) begin
      @(negedge clk_sys);
      cyc++;
    end
    checks++;
    if (cli_ack !== 3'b010 || acc_q.size() != 1) begin
      fails++;
      $display("FAIL dl_client_after: ack=%b accesses=%0d required 010 and 1", cli_ack, acc_q.size());
    end else begin
      a = acc_q.pop_front();
      checks++;
      if (a.we !== 1'b1 || a.addr !== 23'h000040 || a.data !== 8'h77) begin
        fails++;
        $display("FAIL dl_client_txn: we=%b addr=%h data=%h required 1 000040 77", a.we, a.addr, a.data);
      end
      model_ptr = 2;
    end
    cli_req[1] = 1'b0;
    acc_q.delete();
    @(negedge clk_sys);
  endtask

  task automatic test_overflow();
    int cyc;
    acc_t a;
    resp_en = 1'b0;
    @(negedge clk_sys);
    dl_active = 1'b1;
    for (int k = 0; k <= CAP; k++) begin
      if (k == CAP) begin
        checks++;
        if ({dl_busy, dl_overflow} !== 2'b10) begin fails++; $display("FAIL ovf_full: busy=%b ovf=%b required 1 0", dl_busy, dl_overflow); end
      end
      dl_wr = 1'b1;
      dl_addr = 23'h000100 + 23'(k);
      dl_data = 8'h11 * 8'(k + 1);
      @(negedge clk_sys);
    end
    dl_wr = 1'b0;
    checks++;
    if (dl_overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: ovf=%b required 1", dl_overflow); end
    resp_en = 1'b1;
    cyc = 0;
    while (acc_q.size() < CAP && cyc < 300) begin
      @(negedge clk_sys);
      cyc++;
    end
    repeat (12) @(negedge clk_sys);
    checks++;
    if (acc_q.size() != CAP) begin fails++; $display("FAIL ovf_dropped: %0d accesses required %0d", acc_q.size(), CAP); end
    for (int k = 0; k < CAP && acc_q.size() > 0; k++) begin
      a = acc_q.pop_front();
      checks++;
      if (a.we !== 1'b1 || a.addr !== 23'h000100 + 23'(k) || a.data !== 8'h11 * 8'(k + 1)) begin
        fails++;
        $display("FAIL ovf_write: #%0d addr=%h data=%h required %h %h", k, a.addr, a.data, 23'h000100 + 23'(k), 8'h11 * 8'(k + 1));
      end
    end
    acc_q.delete();
    dl_active = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (dl_overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: ovf=%b required 1", dl_overflow); end
    dl_active = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (dl_overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: ovf=%b required 0 after dl_active rise", dl_overflow); end
    dl_active = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_stray_ack();
    @(negedge clk_sys);
    stray_go = 1'b1;
    repeat (4) begin
      @(negedge clk_sys);
      checks++;
      if ({cli_ack, mem_req} !== '0) begin fails++; $display("FAIL stray_ack: ack=%b req=%b required 0", cli_ack, mem_req); end
    end
    checks++;
    if (acc_q.size() != 0) begin fails++; $display("FAIL stray_access: %0d accesses required 0", acc_q.size()); end
    serve(2, 3'b001, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    serve(1, 3'b001, 1'b0, 1'b0);
    resp_en = 1'b0;
    @(negedge clk_sys);
    set_txn(1, 1'b0, 23'h000055, 8'h00);
    cyc = 0;
    while (!mem_req && cyc < 50) begin
      @(negedge clk_sys);
      cyc++;
    end
    checks++;
    if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_mid_issue: req=%b required 1", mem_req); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, cli_ack, dl_busy, dl_overflow} !== '0) begin
      fails++;
      $display("FAIL rst_mid_async: req=%b we=%b addr=%h ack=%b required all 0", mem_req, mem_we, mem_addr, cli_ack);
    end
    cli_req = '0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    model_ptr = 0;
    resp_en = 1'b1;
    repeat (5) begin
      @(negedge clk_sys);
      checks++;
      if ({cli_ack, mem_req} !== '0) begin fails++; $display("FAIL rst_mid_noack: ack=%b req=%b required 0", cli_ack, mem_req); end
    end
    serve(2, 3'b011, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    serve(40, 3'b111, 1'b1, 1'b0);
  endtask

  initial begin
    cli_req = '0;
    cli_we = '0;
    cli_addr = '0;
    cli_wdata = '0;
    dl_active = 1'b0;
    dl_wr = 1'b0;
    dl_addr = '0;
    dl_data = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_download();
    test_overflow();
    test_stray_ack();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
